// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU.
// Divides operand magnitudes, then corrects signs and divide-by-zero in a single fix cycle.
module divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipeline_divider_start,
  input  logic [4:0]       pipeline_divider_subtype,
  input  logic [WIDTH-1:0] pipeline_divider_din1,
  input  logic [WIDTH-1:0] pipeline_divider_din2,
  input  logic             pipeline_divider_flush,
  input  logic             pipeline_divider_stall,
  output logic             divider_pipeline_busy,
  output logic             divider_pipeline_done,
  output logic [WIDTH-1:0] divider_pipeline_dout
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] din1_reg;
  logic             zero_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             mod_reg;
  logic [WIDTH-1:0] dout_reg;

  logic             flush_go;
  logic             accept;
  logic             signed_op;
  logic             is_mod;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign flush_go  = pipeline_divider_flush & ~pipeline_divider_stall;
  assign accept    = pipeline_divider_start & ~flush_go &
                     ((state_reg == IDLE) | ((state_reg == DONE) & ~pipeline_divider_stall));
  assign signed_op = (pipeline_divider_subtype == 5'd0) | (pipeline_divider_subtype == 5'd1);
  assign is_mod    = (pipeline_divider_subtype == 5'd1) | (pipeline_divider_subtype == 5'd3);
  assign mag1      = (signed_op & pipeline_divider_din1[WIDTH-1]) ? -pipeline_divider_din1
                                                                  : pipeline_divider_din1;
  assign mag2      = (signed_op & pipeline_divider_din2[WIDTH-1]) ? -pipeline_divider_din2
                                                                  : pipeline_divider_din2;

  // 33-bit partial remainder: shift in the next dividend bit, then trial-subtract.
  assign shifted   = {rem_reg, quo_reg[WIDTH-1]};
  assign trial     = shifted - {1'b0, div_reg};

  // A zero divisor overrides sign correction with fixed results.
  assign quo_fix   = zero_reg   ? '1       :
                     sign_q_reg ? -quo_reg : quo_reg;
  assign rem_fix   = zero_reg   ? din1_reg :
                     sign_r_reg ? -rem_reg : rem_reg;

  always_comb begin
    state_next = state_reg;
    if (flush_go) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (accept) state_next = CALC;
        CALC: if (cnt_reg == '0) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: begin
          if (accept)                       state_next = CALC;
          else if (!pipeline_divider_stall) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      div_reg    <= '0;
      din1_reg   <= '0;
      zero_reg   <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      mod_reg    <= 1'b0;
      dout_reg   <= '0;
    end else if (accept) begin
      cnt_reg    <= CNT_W'(WIDTH - 1);
      quo_reg    <= mag1;
      rem_reg    <= '0;
      div_reg    <= mag2;
      din1_reg   <= pipeline_divider_din1;
      zero_reg   <= (pipeline_divider_din2 == '0);
      sign_q_reg <= signed_op & (pipeline_divider_din1[WIDTH-1] ^ pipeline_divider_din2[WIDTH-1]);
      sign_r_reg <= signed_op & pipeline_divider_din1[WIDTH-1];
      mod_reg    <= is_mod;
    end else if (!flush_go) begin
      if (state_reg == CALC) begin
        cnt_reg <= cnt_reg - 1'b1;
        if (!trial[WIDTH]) begin
          rem_reg <= trial[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
          rem_reg <= shifted[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
        end
      end else if (state_reg == FIX) begin
        dout_reg <= mod_reg ? rem_fix : quo_fix;
      end
    end
  end

  assign divider_pipeline_busy = (state_reg == CALC) | (state_reg == FIX);
  assign divider_pipeline_done = (state_reg == DONE);
  assign divider_pipeline_dout = dout_reg;

endmodule
